// File: rtl/cpu_cu_pkg.sv
// Shared definitions for the cpu_cu control unit: FSM state encodings,
// instruction class codes, branch condition codes and ALU pass-through ops.
package cu_pkg;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EX_ALU  = 4'd3,
        ST_EX_LD   = 4'd4,
        ST_EX_ST   = 4'd5,
        ST_EX_LDI  = 4'd6,
        ST_EX_JMP  = 4'd7,
        ST_EX_BR   = 4'd8,
        ST_HALT    = 4'd9,
        ST_ILLEGAL = 4'd10
    } state_e;

    // Instruction class, IR[15:13]
    typedef enum logic [2:0] {
        CLS_MISC = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_LDI  = 3'd4,
        CLS_JMP  = 3'd5,
        CLS_BR   = 3'd6,
        CLS_RSVD = 3'd7
    } cls_e;

    // Branch condition, IR[11:9]
    typedef enum logic [2:0] {
        BR_ALWAYS = 3'd0,
        BR_Z      = 3'd1,
        BR_NZ     = 3'd2,
        BR_C      = 3'd3,
        BR_NC     = 3'd4,
        BR_N      = 3'd5,
        BR_NN     = 3'd6,
        BR_RSVD   = 3'd7
    } brc_e;

    // Misc-class sub-opcodes, IR[12:9]
    localparam logic [3:0] MISC_NOP = 4'h0;
    localparam logic [3:0] MISC_HLT = 4'h1;

    localparam logic [3:0] ALU_PASS_R = 4'h0;
    localparam logic [3:0] ALU_PASS_S = 4'h1;

    // Evaluate a branch condition against the latched status flags.
    function automatic logic br_taken(input brc_e cond, input logic fc,
                                      input logic fn, input logic fz);
        logic t;
        t = 1'b0;
        case (cond)
            BR_ALWAYS: t = 1'b1;
            BR_Z:      t = fz;
            BR_NZ:     t = ~fz;
            BR_C:      t = fc;
            BR_NC:     t = ~fc;
            BR_N:      t = fn;
            BR_NN:     t = ~fn;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_cu_status.sv
// Status flag register (C, N, Z) for the control unit: asynchronous
// active-low clear, loads only when ld_i is high.
module cu_status_reg (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ld_i,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);

    logic [2:0] flags_q;

    // Flag storage, cleared asynchronously by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '0;
        end else if (ld_i) begin
            flags_q <= d_i;
        end
    end

    assign q_o = flags_q;

endmodule

// File: rtl/cpu_cu.sv
// cpu_cu: fetch/decode/execute control unit driving the CPU execution unit.
// Optional build macro CU_ILLEGAL_TRAP_EN: when defined, illegal encodings
// trap into a terminal ILLEGAL state; otherwise they behave as NOP.
module cpu_cu
    import cu_pkg::*;
#(
    parameter int unsigned OPW         = 3,
    parameter int unsigned RST_PC_HOLD = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR_Out,
    input  logic        carry,
    input  logic        N,
    input  logic        Z,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        pc_sel,
    output logic        adr_sel,
    output logic        S_Sel,
    output logic        W_En,
    output logic        ir_ld,
    output logic        mw_en,
    output logic [3:0]  Alu_Op,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic        flag_c,
    output logic        flag_n,
    output logic        flag_z,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state_out
);

    localparam logic [1:0] HOLD = 2'(RST_PC_HOLD);

`ifdef CU_ILLEGAL_TRAP_EN
    localparam state_e BAD_NEXT = ST_ILLEGAL;
`else
    localparam state_e BAD_NEXT = ST_FETCH;
`endif

    state_e     state_q, state_d;
    logic [1:0] hold_q, hold_d;
    logic       flag_ld;
    logic [2:0] flags_q;
    cls_e       cls;
    brc_e       brc;
    logic [3:0] sub_op;

    assign cls    = cls_e'(IR_Out[15 -: OPW]);
    assign brc    = brc_e'(IR_Out[11:9]);
    assign sub_op = IR_Out[12:9];

    // State register and reset hold counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state and control-output decode
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        pc_sel  = 1'b0;
        adr_sel = 1'b0;
        S_Sel   = 1'b0;
        W_En    = 1'b0;
        ir_ld   = 1'b0;
        mw_en   = 1'b0;
        Alu_Op  = ALU_PASS_R;
        halted  = 1'b0;
        illegal = 1'b0;
        flag_ld = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (hold_q == HOLD) begin
                    state_d = ST_FETCH;
                end else begin
                    hold_d = hold_q + 2'd1;
                end
            end
            ST_FETCH: begin
                ir_ld   = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (cls)
                    CLS_MISC: begin
                        if (sub_op == MISC_NOP) begin
                            state_d = ST_FETCH;
                        end else if (sub_op == MISC_HLT) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = BAD_NEXT;
                        end
                    end
                    CLS_ALU:  state_d = ST_EX_ALU;
                    CLS_LD:   state_d = ST_EX_LD;
                    CLS_ST:   state_d = ST_EX_ST;
                    CLS_LDI:  state_d = ST_EX_LDI;
                    CLS_JMP:  state_d = ST_EX_JMP;
                    CLS_BR:   state_d = ST_EX_BR;
                    default:  state_d = BAD_NEXT;
                endcase
            end
            ST_EX_ALU: begin
                Alu_Op  = IR_Out[12:9];
                W_En    = 1'b1;
                flag_ld = 1'b1;
                state_d = ST_FETCH;
            end
            ST_EX_LD: begin
                adr_sel = 1'b1;
                S_Sel   = 1'b1;
                Alu_Op  = ALU_PASS_S;
                W_En    = 1'b1;
                state_d = ST_FETCH;
            end
            ST_EX_ST: begin
                adr_sel = 1'b1;
                Alu_Op  = ALU_PASS_S;
                mw_en   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_EX_LDI: begin
                S_Sel   = 1'b1;
                Alu_Op  = ALU_PASS_S;
                W_En    = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_EX_JMP: begin
                Alu_Op  = ALU_PASS_R;
                pc_sel  = 1'b1;
                pc_ld   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_EX_BR: begin
                if (brc == BR_RSVD) begin
                    state_d = BAD_NEXT;
                end else begin
                    pc_ld   = br_taken(brc, flags_q[2], flags_q[1], flags_q[0]);
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_ILLEGAL: begin
`ifdef CU_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`else
                state_d = ST_FETCH;
`endif
            end
            default: state_d = ST_RESET;
        endcase
    end

    cu_status_reg u_status (
        .clk_i  (clock),
        .rst_ni (reset),
        .ld_i   (flag_ld),
        .d_i    ({carry, N, Z}),
        .q_o    (flags_q)
    );

    // Register fields pass straight through except while in RESET
    assign W_Adr  = (state_q == ST_RESET) ? '0 : IR_Out[8:6];
    assign R_Adr  = (state_q == ST_RESET) ? '0 : IR_Out[5:3];
    assign S_Adr  = (state_q == ST_RESET) ? '0 : IR_Out[2:0];

    assign flag_c    = flags_q[2];
    assign flag_n    = flags_q[1];
    assign flag_z    = flags_q[0];
    assign state_out = state_q;

endmodule

// File: tb/tb_cpu_cu.sv
// Testbench for cpu_cu: instruction-level model checked every negedge,
// plus directed literal checks. Honours CU_ILLEGAL_TRAP_EN.
module tb_cpu_cu;

    localparam int HOLD = 0;

    localparam int M_RESET  = 0;
    localparam int M_FETCH  = 1;
    localparam int M_DECODE = 2;
    localparam int M_EXEC   = 3;
    localparam int M_HALT   = 4;
    localparam int M_TRAP   = 5;
`ifdef CU_ILLEGAL_TRAP_EN
    localparam int M_BAD = M_TRAP;
`else
    localparam int M_BAD = M_FETCH;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IR_Out = 16'h0000;
    logic        carry = 1'b0, N = 1'b0, Z = 1'b0;
    logic        pc_inc, pc_ld, pc_sel, adr_sel, S_Sel, W_En, ir_ld, mw_en;
    logic [3:0]  Alu_Op;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        flag_c, flag_n, flag_z, halted, illegal;
    logic [3:0]  state_out;

    int total = 0;
    int bad   = 0;

    cpu_cu #(.OPW(3), .RST_PC_HOLD(HOLD)) dut (
        .clock(clock), .reset(reset), .IR_Out(IR_Out),
        .carry(carry), .N(N), .Z(Z),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_sel(pc_sel), .adr_sel(adr_sel),
        .S_Sel(S_Sel), .W_En(W_En), .ir_ld(ir_ld), .mw_en(mw_en),
        .Alu_Op(Alu_Op), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
        .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z),
        .halted(halted), .illegal(illegal), .state_out(state_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    int          m_mode = M_RESET;
    int          m_hold = HOLD;
    logic [15:0] m_ir   = 16'h0000;
    logic        m_c = 1'b0, m_n = 1'b0, m_z = 1'b0;
    bit          cmp_en = 1'b0;

    function automatic bit cond_ok(input logic [2:0] cc, input logic c,
                                   input logic n, input logic z);
        case (cc)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return c;
            3'd4: return !c;
            3'd5: return n;
            3'd6: return !n;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode = M_RESET; m_hold = HOLD;
            m_c = 1'b0; m_n = 1'b0; m_z = 1'b0;
        end else begin
            case (m_mode)
                M_RESET:  if (m_hold == 0) m_mode = M_FETCH; else m_hold--;
                M_FETCH:  m_mode = M_DECODE;
                M_DECODE: begin
                    m_ir = IR_Out;
                    if (IR_Out[15:13] == 3'd0) begin
                        if (IR_Out[12:9] == 4'd0)      m_mode = M_FETCH;
                        else if (IR_Out[12:9] == 4'd1) m_mode = M_HALT;
                        else                           m_mode = M_BAD;
                    end else if (IR_Out[15:13] == 3'd7) begin
                        m_mode = M_BAD;
                    end else begin
                        m_mode = M_EXEC;
                    end
                end
                M_EXEC: begin
                    if (m_ir[15:13] == 3'd1) begin
                        m_c = carry; m_n = N; m_z = Z;
                    end
                    if (m_ir[15:13] == 3'd6 && m_ir[11:9] == 3'd7) m_mode = M_BAD;
                    else m_mode = M_FETCH;
                end
                default: ;
            endcase
        end
    end

    // Compare every DUT output against the model on each negedge
    always @(negedge clock) begin
        logic       e_inc, e_ld, e_sel, e_adr, e_s, e_w, e_ir, e_mw, e_h, e_il;
        logic [3:0] e_op, e_st;
        logic [2:0] e_wa, e_ra, e_sa;
        if (cmp_en) begin
            {e_inc, e_ld, e_sel, e_adr, e_s, e_w, e_ir, e_mw, e_h, e_il} = '0;
            e_op = 4'h0; e_st = 4'h0;
            e_wa = IR_Out[8:6]; e_ra = IR_Out[5:3]; e_sa = IR_Out[2:0];
            case (m_mode)
                M_RESET:  begin e_wa = 3'd0; e_ra = 3'd0; e_sa = 3'd0; end
                M_FETCH:  begin e_st = 4'd1; e_ir = 1'b1; e_inc = 1'b1; end
                M_DECODE: e_st = 4'd2;
                M_EXEC: begin
                    e_st = 4'(2 + int'(m_ir[15:13]));
                    case (m_ir[15:13])
                        3'd1: begin e_op = IR_Out[12:9]; e_w = 1'b1; end
                        3'd2: begin e_adr = 1'b1; e_s = 1'b1; e_op = 4'h1; e_w = 1'b1; end
                        3'd3: begin e_adr = 1'b1; e_op = 4'h1; e_mw = 1'b1; end
                        3'd4: begin e_s = 1'b1; e_op = 4'h1; e_w = 1'b1; e_inc = 1'b1; end
                        3'd5: begin e_sel = 1'b1; e_ld = 1'b1; end
                        default: e_ld = cond_ok(m_ir[11:9], m_c, m_n, m_z);
                    endcase
                end
                M_HALT:   begin e_st = 4'd9;  e_h = 1'b1; end
                default:  begin e_st = 4'd10; e_il = 1'b1; end
            endcase
            chk("m.state_out", 16'(state_out), 16'(e_st));
            chk("m.pc_inc",  16'(pc_inc),  16'(e_inc));
            chk("m.pc_ld",   16'(pc_ld),   16'(e_ld));
            chk("m.pc_sel",  16'(pc_sel),  16'(e_sel));
            chk("m.adr_sel", 16'(adr_sel), 16'(e_adr));
            chk("m.S_Sel",   16'(S_Sel),   16'(e_s));
            chk("m.W_En",    16'(W_En),    16'(e_w));
            chk("m.ir_ld",   16'(ir_ld),   16'(e_ir));
            chk("m.mw_en",   16'(mw_en),   16'(e_mw));
            chk("m.Alu_Op",  16'(Alu_Op),  16'(e_op));
            chk("m.W_Adr",   16'(W_Adr),   16'(e_wa));
            chk("m.R_Adr",   16'(R_Adr),   16'(e_ra));
            chk("m.S_Adr",   16'(S_Adr),   16'(e_sa));
            chk("m.flags",   16'({flag_c, flag_n, flag_z}), 16'({m_c, m_n, m_z}));
            chk("m.halted",  16'(halted),  16'(e_h));
            chk("m.illegal", 16'(illegal), 16'(e_il));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Called in FETCH: present the instruction and advance to its execute cycle
    task automatic run(input logic [15:0] ir);
        IR_Out = ir;
        step();
        step();
    endtask

    task automatic all_zero(input string nm);
        chk({nm, ".enables"}, 16'({pc_inc, pc_ld, pc_sel, adr_sel, S_Sel, W_En, ir_ld, mw_en}), 16'h0);
        chk({nm, ".state"},   16'(state_out), 16'h0);
        chk({nm, ".flags"},   16'({flag_c, flag_n, flag_z}), 16'h0);
        chk({nm, ".misc"},    16'({Alu_Op, W_Adr, R_Adr, S_Adr, halted, illegal}), 16'h0);
    endtask

    task automatic reset_cycle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        #1 all_zero("por");
        step();
        step();
        reset = 1'b1;
        step();
        chk("rel.state", 16'(state_out), 16'd1);
        chk("rel.ir_ld", 16'(ir_ld), 16'd1);
        chk("rel.pc_inc", 16'(pc_inc), 16'd1);

        // ALU op 3, Z set during execute, then BR Z taken on the latched flag
        run(16'h2650);
        chk("alu.W_En", 16'(W_En), 16'd1);
        chk("alu.Alu_Op", 16'(Alu_Op), 16'd3);
        Z = 1'b1;
        step();
        chk("alu.flag_z", 16'(flag_z), 16'd1);
        Z = 1'b0;
        run(16'hC3FE);
        chk("brz.pc_ld", 16'(pc_ld), 16'd1);
        chk("brz.pc_sel", 16'(pc_sel), 16'd0);
        step();

        // ALU leaving C=1 Z=0, then BR Z not taken
        run(16'h2650);
        carry = 1'b1;
        step();
        carry = 1'b0;
        run(16'hC2FE);
        chk("brnz.pc_ld", 16'(pc_ld), 16'd0);
        step();
        chk("brnz.next", 16'(state_out), 16'd1);

        run(16'hC600); step();   // BR C, taken
        run(16'hCC00); step();   // BR !N, taken
        run(16'hCA00); step();   // BR N, not taken

        run(16'h4048);
        chk("ld.adr_sel", 16'(adr_sel), 16'd1);
        chk("ld.S_Sel", 16'(S_Sel), 16'd1);
        chk("ld.W_En", 16'(W_En), 16'd1);
        chk("ld.adrs", 16'({W_Adr, R_Adr}), 16'({3'd1, 3'd1}));
        step();
        run(16'h600A);
        chk("st.mw_en", 16'(mw_en), 16'd1);
        chk("st.W_En", 16'(W_En), 16'd0);
        chk("st.adrs", 16'({R_Adr, S_Adr}), 16'({3'd1, 3'd2}));
        step();
        run(16'h8080);
        chk("ldi.en", 16'({pc_inc, W_En, adr_sel}), 16'b110);
        step();
        run(16'hA018);
        chk("jmp.en", 16'({pc_sel, pc_ld}), 16'b11);
        chk("jmp.Alu_Op", 16'(Alu_Op), 16'd0);
        chk("jmp.R_Adr", 16'(R_Adr), 16'd3);
        step();

        // NOP: two cycles back to FETCH
        run(16'h0000);
        chk("nop.state", 16'(state_out), 16'd1);

`ifndef CU_ILLEGAL_TRAP_EN
        run(16'hCE00);
        chk("brrsvd.pc_ld", 16'(pc_ld), 16'd0);
        step();
        chk("brrsvd.next", 16'(state_out), 16'd1);
`endif

        // Reset mid-FETCH with C still set from earlier ALU op
        IR_Out = 16'h600A;
        chk("pre.flag_c", 16'(flag_c), 16'd1);
        reset = 1'b0;
        #1 all_zero("rst_fetch");
        step();
        reset = 1'b1;
        step();
        chk("rst_fetch.next", 16'(state_out), 16'd1);

        // Reset during a store suppresses the RAM write at once
        run(16'h600A);
        chk("st2.mw_en", 16'(mw_en), 16'd1);
        reset = 1'b0;
        #1 chk("rst_st.mw_en", 16'(mw_en), 16'd0);
        chk("rst_st.state", 16'(state_out), 16'd0);
        step();
        reset = 1'b1;
        step();

        // HLT holds until reset
        run(16'h0200);
        for (int i = 0; i < 10; i++) begin
            chk("hlt.halted", 16'(halted), 16'd1);
            chk("hlt.state", 16'(state_out), 16'd9);
            step();
        end
        reset_cycle();

        // Reserved class
        run(16'hE000);
`ifdef CU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            chk("ill.illegal", 16'(illegal), 16'd1);
            chk("ill.state", 16'(state_out), 16'd10);
            step();
        end
`else
        chk("ill.state", 16'(state_out), 16'd1);
        chk("ill.illegal", 16'(illegal), 16'd0);
        step();
`endif

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
